// File: rtl/cr_xp10_decomp_lz77_pack.sv
// Repacks partial-byte LZ77 beats into dense 8-byte words, flushes the residue on
// end-of-frame markers and reports per-frame byte counts and illegal byte masks.
module cr_xp10_decomp_lz77_pack #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [63:0]      in_data,
    input  logic [1:0]       in_type,
    input  logic [7:0]       in_bytes_valid,
    output logic             in_ready,
    output logic             pk_valid,
    output logic [63:0]      pk_data,
    output logic [1:0]       pk_type,
    output logic [7:0]       pk_bytes_valid,
    input  logic             pk_ready,
    output logic [CNT_W-1:0] pk_frame_bytes,
    output logic             pk_frame_done,
    output logic             pk_mask_err
);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t           state, state_d;
    logic [55:0]      acc, acc_d;
    logic [2:0]       res, res_d;
    logic [1:0]       mk_type, mk_type_d;
    logic [CNT_W-1:0] run_cnt, run_cnt_d, frame_bytes_d;
    logic [CNT_W:0]   cnt_wide;
    logic [CNT_W-1:0] cnt_sat;

    logic             load;
    logic [63:0]      ld_data;
    logic [1:0]       ld_type;
    logic [7:0]       ld_mask;
    logic             err_d;

    logic             slot_free, accept, legal, full;
    logic [3:0]       n, sum;
    logic [63:0]      data_m;
    logic [119:0]     comb;

    function automatic logic [7:0] low_mask(input logic [3:0] k);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = (4'(i) < k);
        return m;
    endfunction

    assign slot_free     = !pk_valid || pk_ready;
    assign in_ready      = !rst && (state == RUN) && slot_free;
    assign accept        = in_valid && in_ready;
    assign pk_frame_done = !rst && pk_valid && pk_ready && pk_type[1];

    // Legal masks are LSB-contiguous: adding one carries through every set bit.
    assign legal = (in_bytes_valid & (in_bytes_valid + 8'd1)) == 8'd0;

    always_comb begin
        n      = '0;
        data_m = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, in_bytes_valid[i]};
            data_m[8*i +: 8] = in_data[8*i +: 8] & {8{in_bytes_valid[i]}};
        end
    end

    assign sum      = {1'b0, res} + n;
    assign full     = sum[3];
    assign comb     = {64'd0, acc} | ({56'd0, data_m} << {res, 3'b000});
    assign cnt_wide = {1'b0, run_cnt} + {{(CNT_W-3){1'b0}}, n};
    assign cnt_sat  = cnt_wide[CNT_W] ? '1 : cnt_wide[CNT_W-1:0];

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state;
        acc_d         = acc;
        res_d         = res;
        mk_type_d     = mk_type;
        run_cnt_d     = run_cnt;
        frame_bytes_d = pk_frame_bytes;
        load          = 1'b0;
        ld_data       = comb[63:0];
        ld_type       = 2'b00;
        ld_mask       = 8'hFF;
        err_d         = 1'b0;

        if (state == FLUSH) begin
            if (slot_free) begin
                load          = 1'b1;
                ld_data       = {8'd0, acc};
                ld_type       = mk_type;
                ld_mask       = low_mask({1'b0, res});
                frame_bytes_d = run_cnt;
                run_cnt_d     = '0;
                acc_d         = '0;
                res_d         = '0;
                state_d       = RUN;
            end
        end else if (accept) begin
            if (!legal) begin
                err_d = 1'b1;
            end else if (full) begin
                // Full word goes out now; a marker parks its residue for one FLUSH cycle.
                load      = 1'b1;
                acc_d     = comb[119:64];
                res_d     = sum[2:0];
                run_cnt_d = cnt_sat;
                if (in_type[1]) begin
                    mk_type_d = in_type;
                    state_d   = FLUSH;
                end
            end else if (in_type[1]) begin
                load          = 1'b1;
                ld_type       = in_type;
                ld_mask       = low_mask(sum);
                frame_bytes_d = cnt_sat;
                run_cnt_d     = '0;
                acc_d         = '0;
                res_d         = '0;
            end else begin
                acc_d     = comb[55:0];
                res_d     = sum[2:0];
                run_cnt_d = cnt_sat;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; every register,
    // datapath included, is cleared so a mid-frame reset leaves no stale residue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            acc            <= '0;
            res            <= '0;
            mk_type        <= '0;
            run_cnt        <= '0;
            pk_valid       <= 1'b0;
            pk_data        <= '0;
            pk_type        <= '0;
            pk_bytes_valid <= '0;
            pk_frame_bytes <= '0;
            pk_mask_err    <= 1'b0;
        end else begin
            state          <= state_d;
            acc            <= acc_d;
            res            <= res_d;
            mk_type        <= mk_type_d;
            run_cnt        <= run_cnt_d;
            pk_frame_bytes <= frame_bytes_d;
            pk_mask_err    <= err_d;
            if (load) begin
                pk_valid       <= 1'b1;
                pk_data        <= ld_data;
                pk_type        <= ld_type;
                pk_bytes_valid <= ld_mask;
            end else if (pk_ready) begin
                pk_valid <= 1'b0;
            end
        end
    end

endmodule
